rename_regfile_mp: RTL and testbench

Multi-ported architectural register file with rename-tag tracking for the out-of-order core. It sits between the decoder/dispatch stage and the ROB. Dispatch allocates ROB tags to destination registers, and in-order ROB commit writes back data and retires tags. Successor to the single-port regfile: parametrised widths and port counts, an explicit busy bit (tag 0 is a legal ROB index), in-group priority rules and indexed read ports.

---
 rtl/rename_regfile_mp_pkg.sv | 27 ++
 rtl/rename_regfile_mp_prio_sel.sv | 29 ++
 rtl/rename_regfile_mp.sv | 187 ++++++++++++++++++
 tb/tb_rename_regfile_mp.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_regfile_mp_pkg.sv
// rename_regfile_mp_pkg
// Shared constants for the rename register file: default data width,
// architectural register count, ROB tag width and slot/port counts. It also
// provides helpers for slicing flattened per-slot vectors and for sizing
// slot-select indices.
// Optional feature macro used by the top: RF_COMMIT_BYPASS_EN.
package rename_regfile_mp_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NREG_DEF     = 32;
  localparam int REG_W_DEF    = $clog2(NREG_DEF);
  localparam int ROB_W_DEF    = 4;
  localparam int DISP_W_DEF   = 2;
  localparam int CMT_W_DEF    = 2;
  localparam int RD_PORTS_DEF = 4;

  // Bit offset of slot 'slot' inside a flattened vector of 'width'-bit fields.
  function automatic int slot_lsb(input int slot, input int width);
    return slot * width;
  endfunction

  // Width of an index that selects one of n slots (at least one bit).
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rename_regfile_mp_prio_sel.sv
// rf_prio_sel
// Last-valid-slot priority selector. Given a per-slot match vector it
// reports whether any slot matched and the index of the highest matching
// slot, which is how later slots override earlier ones in the same group.
// Ports:
//   match_i  in  N      per-slot match flags
//   hit_o    out 1      at least one slot matched
//   idx_o    out SEL_W  index of the highest matching slot (0 when no hit)
module rf_prio_sel #(
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic [N-1:0]     match_i,
  output logic             hit_o,
  output logic [SEL_W-1:0] idx_o
);

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (match_i[i]) begin
        hit_o = 1'b1;
        idx_o = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/rename_regfile_mp.sv
// rename_regfile_mp
// Multi-ported architectural register file with rename-tag tracking.
// Dispatch marks destination registers busy with their ROB tag; in-order
// commit writes data and clears busy when the committing tag is the one
// currently recorded. Register 0 is hard-wired to zero and never busy.
// Ports:
//   clk_in, rst_in (async, active-low), flush_in
//   disp_valid_in/disp_reg_in/disp_tag_in        dispatch slots
//   cmt_valid_in/cmt_reg_in/cmt_tag_in/cmt_data_in commit slots
//   rd_reg_in -> rd_data_out/rd_busy_out/rd_tag_out  combinational read ports
// Optional macro RF_COMMIT_BYPASS_EN: read ports also see same-cycle commits.
module rename_regfile_mp
  import rename_regfile_mp_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int ROB_W    = ROB_W_DEF,
  parameter int DISP_W   = DISP_W_DEF,
  parameter int CMT_W    = CMT_W_DEF,
  parameter int RD_PORTS = RD_PORTS_DEF
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              flush_in,
  input  logic [DISP_W-1:0]                 disp_valid_in,
  input  logic [DISP_W*$clog2(NREG)-1:0]    disp_reg_in,
  input  logic [DISP_W*ROB_W-1:0]           disp_tag_in,
  input  logic [CMT_W-1:0]                  cmt_valid_in,
  input  logic [CMT_W*$clog2(NREG)-1:0]     cmt_reg_in,
  input  logic [CMT_W*ROB_W-1:0]            cmt_tag_in,
  input  logic [CMT_W*XLEN-1:0]             cmt_data_in,
  input  logic [RD_PORTS*$clog2(NREG)-1:0]  rd_reg_in,
  output logic [RD_PORTS*XLEN-1:0]          rd_data_out,
  output logic [RD_PORTS-1:0]               rd_busy_out,
  output logic [RD_PORTS*ROB_W-1:0]         rd_tag_out
);

  localparam int REG_W  = $clog2(NREG);
  localparam int DSEL_W = sel_width(DISP_W);
  localparam int CSEL_W = sel_width(CMT_W);

  logic [REG_W-1:0] disp_reg_a  [DISP_W];
  logic [ROB_W-1:0] disp_tag_a  [DISP_W];
  logic [REG_W-1:0] cmt_reg_a   [CMT_W];
  logic [ROB_W-1:0] cmt_tag_a   [CMT_W];
  logic [XLEN-1:0]  cmt_data_a  [CMT_W];

  logic [XLEN-1:0]  data_q      [NREG];
  logic             busy_q      [NREG];
  logic [ROB_W-1:0] tag_q       [NREG];
  // Register is targeted by an effective (non-flushed) dispatch this cycle.
  logic             disp_any    [NREG];

  genvar gi;

  for (gi = 0; gi < DISP_W; gi++) begin : g_disp_unpack
    assign disp_reg_a[gi] = disp_reg_in[slot_lsb(gi, REG_W) +: REG_W];
    assign disp_tag_a[gi] = disp_tag_in[slot_lsb(gi, ROB_W) +: ROB_W];
  end

  for (gi = 0; gi < CMT_W; gi++) begin : g_cmt_unpack
    assign cmt_reg_a[gi]  = cmt_reg_in[slot_lsb(gi, REG_W) +: REG_W];
    assign cmt_tag_a[gi]  = cmt_tag_in[slot_lsb(gi, ROB_W) +: ROB_W];
    assign cmt_data_a[gi] = cmt_data_in[slot_lsb(gi, XLEN) +: XLEN];
  end

  for (gi = 0; gi < NREG; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign data_q[gi]   = '0;
      assign busy_q[gi]   = 1'b0;
      assign tag_q[gi]    = '0;
      assign disp_any[gi] = 1'b0;
    end else begin : g_arch
      logic [DISP_W-1:0] disp_match;
      logic [CMT_W-1:0]  cmt_match;
      logic [CMT_W-1:0]  clr_match;
      logic              disp_hit;
      logic              cmt_hit;
      logic [DSEL_W-1:0] disp_sel;
      logic [CSEL_W-1:0] cmt_sel;
      logic [XLEN-1:0]   data_d;
      logic              busy_d;
      logic [ROB_W-1:0]  tag_d;

      always_comb begin
        disp_match = '0;
        cmt_match  = '0;
        clr_match  = '0;
        for (int s = 0; s < DISP_W; s++)
          disp_match[s] = disp_valid_in[s] && (disp_reg_a[s] == REG_W'(gi));
        for (int s = 0; s < CMT_W; s++) begin
          cmt_match[s] = cmt_valid_in[s] && (cmt_reg_a[s] == REG_W'(gi));
          // Any slot carrying the recorded tag clears, not only the winner.
          clr_match[s] = cmt_match[s] && (cmt_tag_a[s] == tag_q[gi]);
        end
      end

      rf_prio_sel #(.N(DISP_W), .SEL_W(DSEL_W)) u_disp_sel (
        .match_i (disp_match),
        .hit_o   (disp_hit),
        .idx_o   (disp_sel)
      );

      rf_prio_sel #(.N(CMT_W), .SEL_W(CSEL_W)) u_cmt_sel (
        .match_i (cmt_match),
        .hit_o   (cmt_hit),
        .idx_o   (cmt_sel)
      );

      assign disp_any[gi] = disp_hit && !flush_in;

      always_comb begin
        data_d = data_q[gi];
        busy_d = busy_q[gi];
        tag_d  = tag_q[gi];
        // Commit data lands even under flush: it is older than flushed work.
        if (cmt_hit)
          data_d = cmt_data_a[cmt_sel];
        if (flush_in) begin
          busy_d = 1'b0;
        end else if (disp_any[gi]) begin
          busy_d = 1'b1;
          tag_d  = disp_tag_a[disp_sel];
        end else if (|clr_match) begin
          busy_d = 1'b0;
        end
      end

      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          data_q[gi] <= '0;
          busy_q[gi] <= 1'b0;
          tag_q[gi]  <= '0;
        end else begin
          data_q[gi] <= data_d;
          busy_q[gi] <= busy_d;
          tag_q[gi]  <= tag_d;
        end
      end
    end
  end

  for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
    logic [REG_W-1:0] rd_reg;
    logic [XLEN-1:0]  rd_data;
    logic             rd_busy;

    assign rd_reg = rd_reg_in[slot_lsb(gi, REG_W) +: REG_W];

`ifdef RF_COMMIT_BYPASS_EN
    logic [CMT_W-1:0]  byp_match;
    logic              byp_hit;
    logic [CSEL_W-1:0] byp_sel;

    always_comb begin
      byp_match = '0;
      for (int s = 0; s < CMT_W; s++)
        byp_match[s] = cmt_valid_in[s] && (rd_reg != '0) && (cmt_reg_a[s] == rd_reg);
    end

    rf_prio_sel #(.N(CMT_W), .SEL_W(CSEL_W)) u_byp_sel (
      .match_i (byp_match),
      .hit_o   (byp_hit),
      .idx_o   (byp_sel)
    );

    // Tag is never bypassed: a same-cycle dispatch is not forwarded.
    always_comb begin
      rd_data = data_q[rd_reg];
      rd_busy = busy_q[rd_reg];
      if (byp_hit) begin
        rd_data = cmt_data_a[byp_sel];
        if ((cmt_tag_a[byp_sel] == tag_q[rd_reg]) && !disp_any[rd_reg])
          rd_busy = 1'b0;
      end
    end
`else
    assign rd_data = data_q[rd_reg];
    assign rd_busy = busy_q[rd_reg];
`endif

    assign rd_data_out[slot_lsb(gi, XLEN) +: XLEN]  = rd_data;
    assign rd_busy_out[gi]                          = rd_busy;
    assign rd_tag_out[slot_lsb(gi, ROB_W) +: ROB_W] = tag_q[rd_reg];
  end

endmodule

// File: tb/tb_rename_regfile_mp.sv
module tb_rename_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REG_W = 5;
  localparam int ROB_W = 4;
  localparam int RDP = 4;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         flush_in;
  logic [1:0]   disp_valid_in;
  logic [9:0]   disp_reg_in;
  logic [7:0]   disp_tag_in;
  logic [1:0]   cmt_valid_in;
  logic [9:0]   cmt_reg_in;
  logic [7:0]   cmt_tag_in;
  logic [63:0]  cmt_data_in;
  logic [19:0]  rd_reg_in;
  logic [127:0] rd_data_out;
  logic [3:0]   rd_busy_out;
  logic [15:0]  rd_tag_out;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  rename_regfile_mp dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .flush_in      (flush_in),
    .disp_valid_in (disp_valid_in),
    .disp_reg_in   (disp_reg_in),
    .disp_tag_in   (disp_tag_in),
    .cmt_valid_in  (cmt_valid_in),
    .cmt_reg_in    (cmt_reg_in),
    .cmt_tag_in    (cmt_tag_in),
    .cmt_data_in   (cmt_data_in),
    .rd_reg_in     (rd_reg_in),
    .rd_data_out   (rd_data_out),
    .rd_busy_out   (rd_busy_out),
    .rd_tag_out    (rd_tag_out)
  );

  // Behavioural reference: architectural state as plain arrays.
  logic [31:0] m_data [NREG];
  logic        m_busy [NREG];
  logic [3:0]  m_tag  [NREG];

  typedef struct {
    logic [1:0]  dv;
    logic [9:0]  dr;
    logic [7:0]  dt;
    logic [1:0]  cv;
    logic [9:0]  cr;
    logic [7:0]  ct;
    logic [63:0] cd;
    logic        fl;
    logic [4:0]  probe;
    logic [31:0] ed;
    logic        eb;
    logic [3:0]  et;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] dv, logic [4:0] dr1, logic [4:0] dr0,
                              logic [3:0] dt1, logic [3:0] dt0, logic [1:0] cv,
                              logic [4:0] cr1, logic [4:0] cr0, logic [3:0] ct1,
                              logic [3:0] ct0, logic [31:0] cd1, logic [31:0] cd0,
                              logic fl, logic [4:0] probe, logic [31:0] ed,
                              logic eb, logic [3:0] et);
    vec_t v;
    v.dv = dv; v.dr = {dr1, dr0}; v.dt = {dt1, dt0};
    v.cv = cv; v.cr = {cr1, cr0}; v.ct = {ct1, ct0}; v.cd = {cd1, cd0};
    v.fl = fl; v.probe = probe; v.ed = ed; v.eb = eb; v.et = et;
    return v;
  endfunction

  task automatic idle();
    flush_in = 1'b0;
    disp_valid_in = '0; disp_reg_in = '0; disp_tag_in = '0;
    cmt_valid_in = '0; cmt_reg_in = '0; cmt_tag_in = '0; cmt_data_in = '0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
    end
  endtask

  // Apply the current inputs to the reference state as one clock edge.
  task automatic model_step();
    logic [31:0] nd [NREG];
    logic        nb [NREG];
    logic [3:0]  nt [NREG];
    for (int r = 0; r < NREG; r++) begin
      nd[r] = m_data[r]; nb[r] = m_busy[r]; nt[r] = m_tag[r];
    end
    for (int s = 0; s < 2; s++)
      if (cmt_valid_in[s] && cmt_reg_in[s*5 +: 5] != 0)
        nd[cmt_reg_in[s*5 +: 5]] = cmt_data_in[s*32 +: 32];
    for (int r = 1; r < NREG; r++) begin
      bit dispatched = 0;
      bit cleared = 0;
      logic [3:0] newtag = '0;
      for (int s = 0; s < 2; s++) begin
        if (disp_valid_in[s] && disp_reg_in[s*5 +: 5] == r[4:0]) begin
          dispatched = 1; newtag = disp_tag_in[s*4 +: 4];
        end
        if (cmt_valid_in[s] && cmt_reg_in[s*5 +: 5] == r[4:0] &&
            cmt_tag_in[s*4 +: 4] == m_tag[r])
          cleared = 1;
      end
      if (flush_in) nb[r] = 1'b0;
      else if (dispatched) begin nb[r] = 1'b1; nt[r] = newtag; end
      else if (cleared) nb[r] = 1'b0;
    end
    for (int r = 0; r < NREG; r++) begin
      m_data[r] = nd[r]; m_busy[r] = nb[r]; m_tag[r] = nt[r];
    end
  endtask

  task automatic exp_read(input logic [4:0] r, output logic [31:0] d,
                          output logic b, output logic [3:0] t);
    d = m_data[r]; b = m_busy[r]; t = m_tag[r];
`ifdef RF_COMMIT_BYPASS_EN
    begin
      bit disp_r = 0;
      for (int s = 0; s < 2; s++)
        if (disp_valid_in[s] && disp_reg_in[s*5 +: 5] == r && !flush_in) disp_r = 1;
      for (int s = 0; s < 2; s++)
        if (r != 0 && cmt_valid_in[s] && cmt_reg_in[s*5 +: 5] == r) begin
          d = cmt_data_in[s*32 +: 32];
          b = (cmt_tag_in[s*4 +: 4] == m_tag[r] && !disp_r) ? 1'b0 : m_busy[r];
        end
    end
`endif
  endtask

  task automatic check(input string name, input logic [31:0] gd, input logic gb,
                       input logic [3:0] gt, input logic [31:0] ed,
                       input logic eb, input logic [3:0] et);
    checks++;
    if ({gd, gb, gt} !== {ed, eb, et}) begin
      errors++;
      $display("FAIL %s: got data=%h busy=%0d tag=%0d, expected data=%h busy=%0d tag=%0d",
               name, gd, gb, gt, ed, eb, et);
    end
  endtask

  task automatic check_port(input int p, input string name);
    logic [31:0] ed; logic eb; logic [3:0] et;
    exp_read(rd_reg_in[p*5 +: 5], ed, eb, et);
    check(name, rd_data_out[p*32 +: 32], rd_busy_out[p], rd_tag_out[p*4 +: 4], ed, eb, et);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rd_reg_in = '0;
    rst_in = 1'b0;
    model_reset();
    #12;
    for (int p = 0; p < RDP; p++) rd_reg_in[p*5 +: 5] = 5'(p + 5);
    #1;
    for (int p = 0; p < RDP; p++) check_port(p, "reset_state");
    @(negedge clk_in);
    rst_in = 1'b1;

    // Directed vectors: apply one cycle, then probe one register.
    //            dv    dr1 dr0 dt1 dt0 cv    cr1 cr0 ct1 ct0 cd1    cd0           fl probe exp_d        eb et
    vecs.push_back(mk(2'b01, 0, 5, 0, 3, 2'b00, 0, 0, 0, 0, 0,     0,            0, 5, 32'h0,        1, 3));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0, 2'b01, 0, 5, 0, 3, 0,     32'hDEADBEEF, 0, 5, 32'hDEADBEEF, 0, 3));
    vecs.push_back(mk(2'b01, 0, 5, 0, 3, 2'b00, 0, 0, 0, 0, 0,     0,            0, 5, 32'hDEADBEEF, 1, 3));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0, 2'b01, 0, 5, 0, 2, 0,     32'h1234,     0, 5, 32'h1234,     1, 3));
    vecs.push_back(mk(2'b01, 0, 7, 0, 4, 2'b00, 0, 0, 0, 0, 0,     0,            0, 7, 32'h0,        1, 4));
    vecs.push_back(mk(2'b01, 0, 7, 0, 9, 2'b01, 0, 7, 0, 4, 0,     32'h77,       0, 7, 32'h77,       1, 9));
    vecs.push_back(mk(2'b11, 8, 8, 2, 1, 2'b00, 0, 0, 0, 0, 0,     0,            0, 8, 32'h0,        1, 2));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 9, 9, 0, 0, 32'h22, 32'h11,      0, 9, 32'h22,       0, 0));
    vecs.push_back(mk(2'b01, 0, 10, 0, 1, 2'b00, 0, 0, 0, 0, 0,    0,            0, 10, 32'h0,       1, 1));
    vecs.push_back(mk(2'b01, 0, 10, 0, 6, 2'b01, 0, 11, 0, 0, 0,   32'h55,       1, 10, 32'h0,       0, 1));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,     0,            0, 11, 32'h55,      0, 0));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,     0,            0, 5, 32'h1234,     0, 3));
    vecs.push_back(mk(2'b01, 0, 0, 0, 7, 2'b01, 0, 0, 0, 0, 0,     32'hFF,       0, 0, 32'h0,        0, 0));
    vecs.push_back(mk(2'b10, 13, 0, 0, 0, 2'b01, 0, 13, 0, 0, 0,   32'h99,       0, 13, 32'h99,      1, 0));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0, 2'b10, 13, 0, 0, 0, 32'hAA, 0,          0, 13, 32'hAA,      0, 0));

    foreach (vecs[i]) begin
      @(negedge clk_in);
      disp_valid_in = vecs[i].dv; disp_reg_in = vecs[i].dr; disp_tag_in = vecs[i].dt;
      cmt_valid_in = vecs[i].cv; cmt_reg_in = vecs[i].cr; cmt_tag_in = vecs[i].ct;
      cmt_data_in = vecs[i].cd; flush_in = vecs[i].fl;
      @(posedge clk_in);
      #1;
      idle();
      rd_reg_in = '0;
      rd_reg_in[4:0] = vecs[i].probe;
      #1;
      check($sformatf("vector_%0d", i), rd_data_out[31:0], rd_busy_out[0], rd_tag_out[3:0],
            vecs[i].ed, vecs[i].eb, vecs[i].et);
      $display("vec %0d: probe x%0d data=%h busy=%0d tag=%0d", i, vecs[i].probe,
               rd_data_out[31:0], rd_busy_out[0], rd_tag_out[3:0]);
    end

    // Asynchronous reset in the middle of traffic, checked before any edge.
    @(negedge clk_in);
    disp_valid_in = 2'b11; disp_reg_in = {5'd20, 5'd21}; disp_tag_in = 8'h3C;
    cmt_valid_in = 2'b11; cmt_reg_in = {5'd5, 5'd9}; cmt_data_in = {32'h1, 32'h2};
    rd_reg_in = {5'd9, 5'd8, 5'd7, 5'd5};
    #2;
    rst_in = 1'b0;
    model_reset();
    #1;
    for (int p = 0; p < RDP; p++) check_port(p, "async_reset_mid_traffic");
    $display("async reset: busy=%b", rd_busy_out);
    @(negedge clk_in);
    rst_in = 1'b1;
    idle();
    @(posedge clk_in);
    #1;
    rd_reg_in = '0;
    rd_reg_in[4:0] = 5'd5;
    #1;
    check("post_reset_x5", rd_data_out[31:0], rd_busy_out[0], rd_tag_out[3:0], 32'h0, 1'b0, 4'h0);

    // Randomized traffic against the reference model.
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk_in);
      flush_in = ($urandom_range(0, 15) == 0);
      disp_valid_in = 2'($urandom);
      cmt_valid_in = 2'($urandom);
      for (int s = 0; s < 2; s++) begin
        logic [4:0] cr;
        disp_reg_in[s*5 +: 5] = 5'($urandom_range(0, 15));
        disp_tag_in[s*4 +: 4] = 4'($urandom);
        cr = 5'($urandom_range(0, 15));
        cmt_reg_in[s*5 +: 5] = cr;
        cmt_tag_in[s*4 +: 4] = ($urandom_range(0, 1) == 1) ? m_tag[cr] : 4'($urandom);
        cmt_data_in[s*32 +: 32] = $urandom;
      end
      for (int p = 0; p < RDP; p++) rd_reg_in[p*5 +: 5] = 5'($urandom_range(0, 15));
      #1;
      for (int p = 0; p < RDP; p++) check_port(p, $sformatf("random_c%0d_p%0d", cyc, p));
      $display("rand %0d: dv=%b cv=%b fl=%0d busy=%b", cyc, disp_valid_in, cmt_valid_in,
               flush_in, rd_busy_out);
      model_step();
      @(posedge clk_in);
    end

    // Commit-to-read visibility in the commit cycle.
    @(negedge clk_in);
    idle();
    disp_valid_in = 2'b01; disp_reg_in[4:0] = 5'd12; disp_tag_in[3:0] = 4'd5;
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    idle();
    cmt_valid_in = 2'b01; cmt_reg_in[4:0] = 5'd12; cmt_tag_in[3:0] = 4'd5;
    cmt_data_in[31:0] = 32'hABCD;
    rd_reg_in = '0;
    rd_reg_in[4:0] = 5'd12;
    #1;
`ifdef RF_COMMIT_BYPASS_EN
    check("bypass_same_cycle", rd_data_out[31:0], rd_busy_out[0], rd_tag_out[3:0],
          32'hABCD, 1'b0, 4'd5);
`else
    check("no_bypass_same_cycle", rd_data_out[31:0], rd_busy_out[0], rd_tag_out[3:0],
          m_data[12], 1'b1, 4'd5);
`endif
    $display("commit x12 same cycle: data=%h busy=%0d", rd_data_out[31:0], rd_busy_out[0]);
    model_step();
    @(posedge clk_in);
    #1;
    idle();
    #1;
    check("commit_after_edge", rd_data_out[31:0], rd_busy_out[0], rd_tag_out[3:0],
          32'hABCD, 1'b0, 4'd5);
    $display("commit x12 after edge: data=%h busy=%0d", rd_data_out[31:0], rd_busy_out[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
